quicksort_ctrl: RTL and testbench
=================================

Name: quicksort_ctrl

Overview:
- Initiator side of the partition handshake: owns the working array and an explicit (lo,hi) range stack.
- Repeatedly issues ranges to the partition engine, absorbs each returned array and pivot index, and pushes the resulting sub-ranges.
- Sits between the top-level sort request interface and the partition engine.
- Declares the sort complete when the stack empties.

Parameters:
ARR_WIDTH, 4, number of array elements
ELEM_W, 4, bits per element
IDX_W, 4, bits per index (lo/hi/pivot)
STACK_DEPTH, 8, range-stack entries, each entry {lo,hi}
TIMEOUT_CYC, 64, watchdog limit in cycles (used only with QS_TIMEOUT_EN)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
sort_start  in  1  request; sampled only in IDLE
array_in  in  ARR_WIDTH*ELEM_W  unsorted array; element 0 in the MS slice
sort_busy  out  1  high from the cycle after start acceptance until the sort_done cycle
sort_done  out  1  one-cycle completion pulse
sort_err  out  1  sticky error flag; cleared on next accepted sort_start
array_sorted  out  ARR_WIDTH*ELEM_W  result; element 0 in the MS slice
part_array  out  ARR_WIDTH*ELEM_W  working array driven to the partition engine
part_lo  out  IDX_W  range low index
part_hi  out  IDX_W  range high index
part_start  out  1  one-cycle request pulse
part_array_ret  in  ARR_WIDTH*ELEM_W  partitioned array from the engine
part_valid  in  1  engine result strobe
part_pivot  in  IDX_W  final pivot position

Behaviour:
- Reset: all outputs 0, stack pointer 0, state IDLE. Reset mid-sort aborts immediately; no sort_done is issued.
- States: IDLE, LOAD, POP, ISSUE, WAIT, PUSH_R, PUSH_L, DONE.
- IDLE: on sort_start=1:
  - capture array_in into the working array;
  - clear sort_err;
  - push {0, ARR_WIDTH-1};
  - go to LOAD.
- LOAD: one cycle; drive the working array onto part_array; go to POP.
- POP:
  - stack empty: go to DONE.
  - otherwise pop {lo,hi}. If hi>lo, latch part_lo/part_hi and go to ISSUE; if hi<=lo, stay in POP for the next entry.
- ISSUE: part_start=1 for exactly one cycle; go to WAIT.
- WAIT:
  - part_array, part_lo and part_hi are held stable.
  - In the cycle part_valid=1: working array <= part_array_ret; capture p=part_pivot; go to PUSH_R.
  - part_valid outside WAIT is ignored.
- PUSH_R: push {p+1, hi} only if p+1<hi; otherwise no push. Go to PUSH_L.
- PUSH_L: push {lo, p-1} only if p>lo (never underflows at p=0). Go to POP. Left range is popped first (LIFO).
- Stack overflow: a push attempted while the stack holds STACK_DEPTH entries sets sort_err=1, discards the push and goes to DONE.
- DONE: array_sorted <= working array; sort_done=1 for one cycle; go to IDLE.
- array_sorted holds its value until the next DONE.
- sort_start while busy is ignored.
- Each stack push/pop takes one cycle; no simultaneous push and pop.
- Width rule: p+1 and p-1 are computed in IDX_W+1 bits for the range checks.
- part_pivot outside [lo,hi] is treated as an error: sort_err=1, go to DONE.

Optional Feature:
QS_TIMEOUT_EN
- Defined:
  - a counter runs in WAIT and clears on entry to WAIT;
  - if it reaches TIMEOUT_CYC without part_valid, sort_err=1 and the block goes to DONE, emitting sort_done with the current working array.
- Undefined: no counter is built; WAIT waits indefinitely.

Test Plan:
- array_in {3,1,2,0} with the bench's behavioural Lomuto partition model -> sort_done once; array_sorted {0,1,2,3}; sort_err=0; first part_start carries lo=0, hi=3.
- Already-sorted {0,1,2,3} -> array_sorted {0,1,2,3}; count of part_start equals the number of ranges with hi>lo; no overflow.
- All-equal {5,5,5,5} -> array_sorted {5,5,5,5}; no push with lo>hi ever issued; sort_done within a bounded cycle count.
- STACK_DEPTH=1, input {3,2,1,0} with pivot returned mid-range -> sort_err=1, sort_done pulses, block returns to IDLE.
- Reset asserted in WAIT, then released, then a new sort {2,0,3,1} -> no stale sort_done; result {0,1,2,3}.
- QS_TIMEOUT_EN, TIMEOUT_CYC=64, bench never asserts part_valid -> sort_err=1 and sort_done exactly 64 cycles after entering WAIT (±1 per stated count start).

Source files
------------

// File: rtl/quicksort_ctrl.sv
// quicksort_ctrl: iterative quicksort initiator with an explicit {lo,hi} range stack
// Ports: clock/reset (sync, active-high); sort_start/array_in request a sort,
// sort_busy/sort_done/sort_err/array_sorted report it; part_* is the handshake
// with the partition engine (part_start pulse out, part_valid/part_array_ret/part_pivot back).
// Optional: define QS_TIMEOUT_EN to build a WAIT watchdog of TIMEOUT_CYC cycles.
module quicksort_ctrl #(
  parameter int ARR_WIDTH = 4,
  parameter int ELEM_W = 4,
  parameter int IDX_W = 4,
  parameter int STACK_DEPTH = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        sort_start,
  input  logic [ARR_WIDTH*ELEM_W-1:0] array_in,
  output logic                        sort_busy,
  output logic                        sort_done,
  output logic                        sort_err,
  output logic [ARR_WIDTH*ELEM_W-1:0] array_sorted,
  output logic [ARR_WIDTH*ELEM_W-1:0] part_array,
  output logic [IDX_W-1:0]            part_lo,
  output logic [IDX_W-1:0]            part_hi,
  output logic                        part_start,
  input  logic [ARR_WIDTH*ELEM_W-1:0] part_array_ret,
  input  logic                        part_valid,
  input  logic [IDX_W-1:0]            part_pivot
);
  localparam int AW = ARR_WIDTH * ELEM_W;
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int TW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, POP, ISSUE, WAIT, PUSH_R, PUSH_L, DONE} state_t;
  state_t state, next;
  logic [AW-1:0] work;
  logic [2*IDX_W-1:0] stk [STACK_DEPTH];
  logic [SPW-1:0] sp;
  logic [TW-1:0] rd, wr;
  logic [IDX_W-1:0] p, top_lo, top_hi;
  logic [IDX_W:0] p_inc;
  logic empty, full, want_r, want_l, bad_piv, tmo;
  assign rd = TW'(sp - SPW'(1));
  assign wr = TW'(sp);
  assign {top_lo, top_hi} = stk[rd];
  assign empty = sp == '0;
  assign full = sp == SPW'(STACK_DEPTH);
  // p+1 is one bit wider so p = 2^IDX_W-1 cannot wrap into a bogus right range
  assign p_inc = {1'b0, p} + (IDX_W + 1)'(1);
  assign want_r = p_inc < {1'b0, part_hi};
  assign want_l = p > part_lo;
  assign bad_piv = part_pivot < part_lo || part_pivot > part_hi;
  assign part_array = work;
`ifdef QS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  // Held at zero outside WAIT, so every entry into WAIT starts a fresh count
  always_ff @(posedge clock) cnt <= (reset || state != WAIT) ? '0 : cnt + CW'(1);
  assign tmo = cnt == CW'(TIMEOUT_CYC - 1);
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clock) state <= reset ? IDLE : next;
  always_comb begin
    next = state;
    part_start = state == ISSUE;
    sort_done = state == DONE;
    sort_busy = state != IDLE;
    case (state)
      IDLE:    next = sort_start ? LOAD : IDLE;
      LOAD:    next = POP;
      POP:     next = empty ? DONE : (top_hi > top_lo ? ISSUE : POP);
      ISSUE:   next = WAIT;
      WAIT:    next = part_valid ? (bad_piv ? DONE : PUSH_R) : (tmo ? DONE : WAIT);
      PUSH_R:  next = (want_r && full) ? DONE : PUSH_L;
      PUSH_L:  next = (want_l && full) ? DONE : POP;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sp <= '0;
      work <= '0;
      p <= '0;
      part_lo <= '0;
      part_hi <= '0;
      sort_err <= 1'b0;
      array_sorted <= '0;
    end else begin
      case (state)
        IDLE: if (sort_start) begin
          work <= array_in;
          sort_err <= 1'b0;
          stk[0] <= {IDX_W'(0), IDX_W'(ARR_WIDTH - 1)};
          sp <= SPW'(1);
        end
        POP: if (!empty) begin
          sp <= sp - SPW'(1);
          if (top_hi > top_lo) begin
            part_lo <= top_lo;
            part_hi <= top_hi;
          end
        end
        WAIT: if (part_valid) begin
          if (bad_piv) sort_err <= 1'b1;
          else begin
            work <= part_array_ret;
            p <= part_pivot;
          end
        end else if (tmo) sort_err <= 1'b1;
        PUSH_R: if (want_r) begin
          if (full) sort_err <= 1'b1;
          else begin
            stk[wr] <= {IDX_W'(p_inc), part_hi};
            sp <= sp + SPW'(1);
          end
        end
        PUSH_L: if (want_l) begin
          if (full) sort_err <= 1'b1;
          else begin
            stk[wr] <= {part_lo, p - IDX_W'(1)};
            sp <= sp + SPW'(1);
          end
        end
        DONE: array_sorted <= work;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_quicksort_ctrl.sv
// tb_quicksort_ctrl: randomized and directed checks of quicksort_ctrl against a behavioural model
module tb_quicksort_ctrl;
  logic clock = 0, reset = 1;
  always #5 clock = ~clock;
  logic start_a = 0, start_b = 0, pv_a = 0, pv_b = 0;
  logic [15:0] in_a = 0, in_b = 0, ret_a = 0, ret_b = 0, sorted_a, sorted_b, parr_a, parr_b;
  logic [3:0] piv_a = 0, piv_b = 0, plo_a, phi_a, plo_b, phi_b;
  logic busy_a, done_a, err_a, pst_a, busy_b, done_b, err_b, pst_b;
  int total = 0, passed = 0;
  int lat_a = 2;
  bit eng_a_on = 1;
  int n_done_a = 0, n_iss_a = 0, bad_rng_a = 0, arr_bad_a = 0, stab_bad_a = 0, n_done_b = 0;
  int b_done, b_iss, b_rng, b_arr, b_stab;
  logic [3:0] flo_a = 0, fhi_a = 0;
  logic [15:0] trk_a = 0, r_a, snap_a;
  logic [3:0] slo_a, shi_a;
  int pp_a;

  quicksort_ctrl dut_a (.clock(clock), .reset(reset), .sort_start(start_a), .array_in(in_a),
    .sort_busy(busy_a), .sort_done(done_a), .sort_err(err_a), .array_sorted(sorted_a),
    .part_array(parr_a), .part_lo(plo_a), .part_hi(phi_a), .part_start(pst_a),
    .part_array_ret(ret_a), .part_valid(pv_a), .part_pivot(piv_a));
  quicksort_ctrl #(.STACK_DEPTH(1)) dut_b (.clock(clock), .reset(reset), .sort_start(start_b),
    .array_in(in_b), .sort_busy(busy_b), .sort_done(done_b), .sort_err(err_b),
    .array_sorted(sorted_b), .part_array(parr_b), .part_lo(plo_b), .part_hi(phi_b),
    .part_start(pst_b), .part_array_ret(ret_b), .part_valid(pv_b), .part_pivot(piv_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void lomuto(input logic [15:0] v, input int lo, input int hi,
                                 output logic [15:0] o, output int p);
    logic [3:0] a [4];
    logic [3:0] t, pv;
    int i;
    for (int k = 0; k < 4; k++) a[k] = v[(3-k)*4 +: 4];
    pv = a[hi];
    i = lo;
    for (int j = lo; j < hi; j++)
      if (a[j] < pv) begin
        t = a[i]; a[i] = a[j]; a[j] = t; i++;
      end
    t = a[i]; a[i] = a[hi]; a[hi] = t;
    p = i;
    for (int k = 0; k < 4; k++) o[(3-k)*4 +: 4] = a[k];
  endfunction

  function automatic logic [15:0] isort(input logic [15:0] v);
    logic [3:0] a [4];
    logic [3:0] t;
    logic [15:0] o;
    for (int k = 0; k < 4; k++) a[k] = v[(3-k)*4 +: 4];
    for (int i = 1; i < 4; i++)
      for (int j = i; j > 0; j--)
        if (a[j] < a[j-1]) begin
          t = a[j]; a[j] = a[j-1]; a[j-1] = t;
        end
    for (int k = 0; k < 4; k++) o[(3-k)*4 +: 4] = a[k];
    return o;
  endfunction

  // Number of partition requests a recursive quicksort with Lomuto makes
  function automatic int ref_issues(input logic [15:0] v);
    int qlo [$], qhi [$];
    int lo, hi, p, n;
    logic [15:0] w;
    w = v; n = 0;
    qlo.push_back(0); qhi.push_back(3);
    while (qlo.size() > 0) begin
      lo = qlo.pop_back(); hi = qhi.pop_back();
      if (hi > lo) begin
        n++;
        lomuto(w, lo, hi, w, p);
        if (p + 1 < hi) begin qlo.push_back(p + 1); qhi.push_back(hi); end
        if (p > lo) begin qlo.push_back(lo); qhi.push_back(p - 1); end
      end
    end
    return n;
  endfunction

  always begin
    @(negedge clock);
    if (pst_a && eng_a_on) begin
      lomuto(parr_a, int'(plo_a), int'(phi_a), r_a, pp_a);
      snap_a = parr_a; slo_a = plo_a; shi_a = phi_a;
      for (int k = 0; k < lat_a; k++) begin
        @(negedge clock);
        if (busy_a && (parr_a !== snap_a || plo_a !== slo_a || phi_a !== shi_a)) stab_bad_a++;
      end
      ret_a = r_a; piv_a = 4'(pp_a); trk_a = r_a; pv_a = 1;
      @(negedge clock);
      pv_a = 0;
    end
  end

  always begin
    @(negedge clock);
    if (pst_b) begin
      @(negedge clock);
      ret_b = parr_b; piv_b = 4'((int'(plo_b) + int'(phi_b)) / 2); pv_b = 1;
      @(negedge clock);
      pv_b = 0;
    end
  end

  always @(negedge clock) begin
    if (done_a) n_done_a <= n_done_a + 1;
    if (done_b) n_done_b <= n_done_b + 1;
    if (pst_a) begin
      n_iss_a <= n_iss_a + 1;
      if (!(phi_a > plo_a)) bad_rng_a <= bad_rng_a + 1;
      if (parr_a !== trk_a) arr_bad_a <= arr_bad_a + 1;
      if (n_iss_a == b_iss) begin flo_a <= plo_a; fhi_a <= phi_a; end
    end
  end

  task automatic sort_a(input logic [15:0] v, output int cyc);
    in_a = v; trk_a = v;
    b_done = n_done_a; b_iss = n_iss_a; b_rng = bad_rng_a; b_arr = arr_bad_a; b_stab = stab_bad_a;
    start_a = 1;
    @(negedge clock);
    start_a = 0;
    check("busy_on", 32'(busy_a), 1);
    cyc = 0;
    while (!done_a && cyc < 1000) begin @(negedge clock); cyc++; end
    @(negedge clock);
  endtask

  task automatic verify_a(input string tag, input logic [15:0] v, input int cyc);
    check({tag, "_bound"}, 32'(cyc < 200), 1);
    check({tag, "_sorted"}, 32'(sorted_a), 32'(isort(v)));
    check({tag, "_done_once"}, 32'(n_done_a - b_done), 1);
    check({tag, "_err"}, 32'(err_a), 0);
    check({tag, "_busy_off"}, 32'(busy_a), 0);
    check({tag, "_issues"}, 32'(n_iss_a - b_iss), 32'(ref_issues(v)));
    check({tag, "_ranges"}, 32'(bad_rng_a - b_rng), 0);
    check({tag, "_part_array"}, 32'(arr_bad_a - b_arr), 0);
    check({tag, "_stable"}, 32'(stab_bad_a - b_stab), 0);
  endtask

  initial begin
    int cyc, k, d0;
    logic [15:0] v;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_err", 32'(err_a), 0);
    check("rst_sorted", 32'(sorted_a), 0);
    check("rst_pstart", 32'(pst_a), 0);
    check("rst_lohi", 32'({plo_a, phi_a}), 0);
    check("rst_parr", 32'(parr_a), 0);
    reset = 0;
    @(negedge clock);
    v = {4'd3, 4'd1, 4'd2, 4'd0};
    sort_a(v, cyc);
    verify_a("t1", v, cyc);
    check("t1_first_lo", 32'(flo_a), 0);
    check("t1_first_hi", 32'(fhi_a), 3);
    check("t1_value", 32'(sorted_a), 32'(16'h0123));
    v = {4'd0, 4'd1, 4'd2, 4'd3};
    sort_a(v, cyc);
    verify_a("sorted_in", v, cyc);
    v = {4'd5, 4'd5, 4'd5, 4'd5};
    sort_a(v, cyc);
    verify_a("all_eq", v, cyc);
    for (int i = 0; i < 6; i++) begin
      v = 16'($urandom);
      lat_a = int'($urandom_range(1, 5));
      sort_a(v, cyc);
      verify_a("rand", v, cyc);
    end
    lat_a = 2;
    d0 = n_done_b;
    in_b = {4'd3, 4'd2, 4'd1, 4'd0};
    start_b = 1;
    @(negedge clock);
    start_b = 0;
    cyc = 0;
    while (!done_b && cyc < 200) begin @(negedge clock); cyc++; end
    check("ovf_done", 32'(done_b), 1);
    check("ovf_err", 32'(err_b), 1);
    @(negedge clock);
    check("ovf_idle", 32'(busy_b), 0);
    check("ovf_done_once", 32'(n_done_b - d0), 1);
    check("ovf_array", 32'(sorted_b), 32'(16'h3210));
    lat_a = 20;
    d0 = n_done_a;
    in_a = {4'd3, 4'd1, 4'd2, 4'd0}; trk_a = in_a;
    start_a = 1;
    @(negedge clock);
    start_a = 0;
    k = 0;
    while (!pst_a && k < 50) begin @(negedge clock); k++; end
    check("rst_mid_issue", 32'(pst_a), 1);
    repeat (2) @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    check("rst_mid_busy", 32'(busy_a), 0);
    check("rst_mid_err", 32'(err_a), 0);
    repeat (30) @(negedge clock);
    check("rst_mid_no_done", 32'(n_done_a - d0), 0);
    check("rst_mid_idle", 32'(busy_a), 0);
    lat_a = 2;
    v = {4'd2, 4'd0, 4'd3, 4'd1};
    sort_a(v, cyc);
    verify_a("after_rst", v, cyc);
    check("after_rst_value", 32'(sorted_a), 32'(16'h0123));
`ifdef QS_TIMEOUT_EN
    eng_a_on = 0;
    d0 = n_done_a;
    in_a = {4'd3, 4'd1, 4'd2, 4'd0};
    start_a = 1;
    @(negedge clock);
    start_a = 0;
    k = 0;
    while (!pst_a && k < 50) begin @(negedge clock); k++; end
    check("tmo_issue", 32'(pst_a), 1);
    k = 0;
    while (!done_a && k < 200) begin @(negedge clock); k++; end
    check("tmo_latency", 32'(k >= 64 && k <= 66), 1);
    check("tmo_err", 32'(err_a), 1);
    @(negedge clock);
    check("tmo_done_once", 32'(n_done_a - d0), 1);
    check("tmo_array", 32'(sorted_a), 32'(16'h3120));
    eng_a_on = 1;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
